// File: rtl/regfile_wb_ctrl_pkg.sv
// rtl/regfile_wb_ctrl_pkg.sv - shared types for the integer writeback path (package riscv_wb_pkg)
package riscv_wb_pkg;

  localparam int XLEN = 64;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LSU
  } wb_src_e;

  // x0 is hardwired to zero, so a result aimed at it never enables the write port
  function automatic logic wb_live(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - producer, register-file and bypass signals of the writeback controller
interface regfile_wb_ctrl_if;
  import riscv_wb_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic [4:0]      rd;
  logic            rd_we;
  logic [XLEN-1:0] rd_data;
  logic [4:0]      byp_rs1;
  logic [4:0]      byp_rs2;
  logic            byp_rs1_hit;
  logic            byp_rs2_hit;
  logic [XLEN-1:0] byp_data;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, byp_rs1, byp_rs2,
    input  alu_ready, lsu_ready, rd, rd_we, rd_data, byp_rs1_hit, byp_rs2_hit, byp_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, byp_rs1, byp_rs2,
    output alu_ready, lsu_ready, rd, rd_we, rd_data, byp_rs1_hit, byp_rs2_hit, byp_data
  );

endinterface

// File: rtl/regfile_wb_ctrl_fifo.sv
// rtl/regfile_wb_ctrl_fifo.sv - wb_fifo: load-result FIFO, wrap-bit pointers, no fall-through
module wb_fifo
  import riscv_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t pop_entry,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_entry_t   mem [DEPTH];

  // Same index with differing wrap bits means the writer is a full lap ahead
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_entry = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_entry;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - ALU/LSU writeback arbiter with starvation guard; WB_BYPASS_EN adds forwarding
module regfile_wb_ctrl
  import riscv_wb_pkg::*;
#(
  parameter int LSU_DEPTH    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic            fifo_full;
  logic            fifo_empty;
  logic            lsu_push;
  logic            lsu_win;
  wb_entry_t       lsu_entry;
  wb_entry_t       fifo_head;
  wb_src_e         wb_src;
  logic [SW-1:0]   starve_cnt;
  logic [4:0]      rd_q;
  logic            rd_we_q;
  logic [XLEN-1:0] rd_data_q;

  assign lsu_entry     = '{rd: bus.lsu_rd, data: bus.lsu_data};
  assign lsu_push      = bus.lsu_valid && !fifo_full;
  assign bus.lsu_ready = !fifo_full;

  wb_fifo #(.DEPTH(LSU_DEPTH)) u_lsu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (lsu_push),
    .push_entry (lsu_entry),
    .pop        (lsu_win),
    .pop_entry  (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // ALU has priority unless the queued loads have already waited STARVE_LIMIT wins
  always_comb begin
    lsu_win = !fifo_empty && (!bus.alu_valid || (starve_cnt >= STARVE_MAX));
    wb_src  = WB_SRC_NONE;
    if (lsu_win) begin
      wb_src = WB_SRC_LSU;
    end else if (bus.alu_valid) begin
      wb_src = WB_SRC_ALU;
    end
  end

  assign bus.alu_ready = !lsu_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q       <= '0;
      rd_we_q    <= 1'b0;
      rd_data_q  <= '0;
      starve_cnt <= '0;
    end else begin
      case (wb_src)
        WB_SRC_ALU: begin
          rd_q      <= bus.alu_rd;
          rd_data_q <= bus.alu_data;
          rd_we_q   <= wb_live(bus.alu_rd);
        end
        WB_SRC_LSU: begin
          rd_q      <= fifo_head.rd;
          rd_data_q <= fifo_head.data;
          rd_we_q   <= wb_live(fifo_head.rd);
        end
        default: rd_we_q <= 1'b0;
      endcase

      if (lsu_win) begin
        starve_cnt <= '0;
      end else if (!fifo_empty && bus.alu_valid && (starve_cnt < STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  assign bus.rd      = rd_q;
  assign bus.rd_we   = rd_we_q;
  assign bus.rd_data = rd_data_q;

`ifdef WB_BYPASS_EN
  // The register file still returns the old value in the cycle its write is in flight
  assign bus.byp_rs1_hit = rd_we_q && (rd_q == bus.byp_rs1) && (bus.byp_rs1 != 5'd0);
  assign bus.byp_rs2_hit = rd_we_q && (rd_q == bus.byp_rs2) && (bus.byp_rs2 != 5'd0);
  assign bus.byp_data    = rd_data_q;
`else
  logic unused_byp;
  assign unused_byp      = ^{bus.byp_rs1, bus.byp_rs2};
  assign bus.byp_rs1_hit = 1'b0;
  assign bus.byp_rs2_hit = 1'b0;
  assign bus.byp_data    = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - queue-model scoreboard plus directed writeback scenarios
module tb_regfile_wb_ctrl;
  import riscv_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl #(.LSU_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: pending loads as a queue, waiting-win count as an integer, last write as plain values
  wb_entry_t   mq[$];
  int          scnt   = 0;
  logic [4:0]  m_rd   = '0;
  logic        m_we   = 1'b0;
  logic [63:0] m_data = '0;

  always @(posedge clk or posedge rst) begin
    bit        has;
    bit        push;
    wb_entry_t e;
    if (rst) begin
      mq.delete();
      scnt = 0; m_rd = '0; m_we = 1'b0; m_data = '0;
    end else begin
      has  = mq.size() > 0;
      push = bus.lsu_valid && (mq.size() < DEPTH);
      if (has && (!bus.alu_valid || scnt >= LIMIT)) begin
        e = mq.pop_front();
        m_rd = e.rd; m_data = e.data; m_we = (e.rd != 0);
        scnt = 0;
      end else if (bus.alu_valid) begin
        m_rd = bus.alu_rd; m_data = bus.alu_data; m_we = (bus.alu_rd != 0);
        if (has && scnt < LIMIT) scnt++;
      end else begin
        m_we = 1'b0;
      end
      if (push) mq.push_back('{rd: bus.lsu_rd, data: bus.lsu_data});
    end
  end

  logic [4:0]  log_rd[$];
  logic [63:0] log_data[$];

  always @(negedge clk) begin
    bit   exp_lsu_win;
    logic e1, e2;
    if (!rst) begin
      exp_lsu_win = (mq.size() > 0) && (!bus.alu_valid || scnt >= LIMIT);
      check("alu_ready", bus.alu_ready, !exp_lsu_win);
      check("lsu_ready", bus.lsu_ready, mq.size() < DEPTH);
      check("rd_we", bus.rd_we, m_we);
      check("rd", bus.rd, m_rd);
      check("rd_data", bus.rd_data, m_data);
`ifdef WB_BYPASS_EN
      e1 = m_we && (m_rd == bus.byp_rs1) && (bus.byp_rs1 != 0);
      e2 = m_we && (m_rd == bus.byp_rs2) && (bus.byp_rs2 != 0);
      check("byp_data", bus.byp_data, m_data);
`else
      e1 = 1'b0;
      e2 = 1'b0;
      check("byp_data", bus.byp_data, 64'd0);
`endif
      check("byp_rs1_hit", bus.byp_rs1_hit, e1);
      check("byp_rs2_hit", bus.byp_rs2_hit, e2);
      if (bus.rd_we) begin
        log_rd.push_back(bus.rd);
        log_data.push_back(bus.rd_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] r, input logic [63:0] d);
    bus.alu_valid = v; bus.alu_rd = r; bus.alu_data = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] r, input logic [63:0] d);
    bus.lsu_valid = v; bus.lsu_rd = r; bus.lsu_data = d;
  endtask

  initial begin
    int k;
    int j;
    bit acc;
    logic [0:10] t3_ready;
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    bus.byp_rs1 = 5'd0;
    bus.byp_rs2 = 5'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_we", bus.rd_we, 0);
    check("reset_rd", bus.rd, 0);
    check("reset_rd_data", bus.rd_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_lsu_ready", bus.lsu_ready, 1);
    check("reset_alu_ready", bus.alu_ready, 1);
    tick();

    // 1: single ALU result
    set_alu(1, 5, 64'hDEAD);
    @(negedge clk);
    check("t1_alu_ready", bus.alu_ready, 1);
    tick();
    set_alu(0, 0, 0);
    @(negedge clk);
    check("t1_rd_we", bus.rd_we, 1);
    check("t1_rd", bus.rd, 5);
    check("t1_rd_data", bus.rd_data, 64'hDEAD);
    tick();
    @(negedge clk);
    check("t1_rd_we_drop", bus.rd_we, 0);
    tick();

    // 2: back-to-back loads, ALU idle; each write lands two cycles after its offer
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_lsu(1, 5'(i + 1), 64'((i + 1) * 'h11));
      else set_lsu(0, 0, 0);
      @(negedge clk);
      if (i < 4) check("t2_lsu_ready", bus.lsu_ready, 1);
      if (i >= 2) begin
        check("t2_rd_we", bus.rd_we, 1);
        check("t2_rd", bus.rd, 64'(i - 1));
        check("t2_rd_data", bus.rd_data, 64'((i - 1) * 'h11));
      end
      tick();
    end
    repeat (2) tick();

    // 3: ALU held busy; loads at cycles 0 and 5 each wait three ALU wins
    t3_ready = 11'b11110_11110_1;
    for (int i = 0; i < 11; i++) begin
      set_alu(1, 5'(10 + i), 64'h100 + 64'(i));
      if (i == 0) set_lsu(1, 7, 64'h77);
      else if (i == 5) set_lsu(1, 8, 64'h88);
      else set_lsu(0, 0, 0);
      @(negedge clk);
      check("t3_alu_ready", bus.alu_ready, t3_ready[i]);
      if (i == 5) begin
        check("t3_x7_rd", bus.rd, 7);
        check("t3_x7_data", bus.rd_data, 64'h77);
      end
      if (i == 10) check("t3_x8_rd", bus.rd, 8);
      tick();
    end
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    repeat (3) tick();

    // 4: fill the FIFO under ALU pressure, offer a fifth while full
    log_rd.delete();
    log_data.delete();
    k = 0;
    for (int i = 0; i < 24; i++) begin
      set_alu(1, 1, 64'(i));
      if (k < 5) set_lsu(1, 5'(20 + k), 64'h2000 + 64'(k));
      else set_lsu(0, 0, 0);
      @(negedge clk);
      if (i == 3) check("t4_ready_before_full", bus.lsu_ready, 1);
      if (i == 4) check("t4_full_ready", bus.lsu_ready, 0);
      if (i == 5) check("t4_ready_after_pop", bus.lsu_ready, 1);
      acc = bus.lsu_valid && bus.lsu_ready;
      tick();
      if (acc) k++;
    end
    set_alu(0, 0, 0);
    set_lsu(0, 0, 0);
    repeat (4) tick();
    j = 0;
    foreach (log_rd[n]) begin
      if (log_rd[n] >= 20) begin
        check("t4_order_rd", log_rd[n], 64'(20 + j));
        check("t4_order_data", log_data[n], 64'h2000 + 64'(j));
        j++;
      end
    end
    check("t4_count", j, 5);

    // 5a: writes aimed at x0 complete but never enable the port
    set_alu(1, 0, 64'hFF);
    @(negedge clk);
    check("t5_x0_alu_ready", bus.alu_ready, 1);
    tick();
    set_alu(0, 0, 0);
    @(negedge clk);
    check("t5_x0_alu_we", bus.rd_we, 0);
    set_lsu(1, 0, 64'h55);
    tick();
    set_lsu(0, 0, 0);
    tick();
    @(negedge clk);
    check("t5_x0_lsu_we", bus.rd_we, 0);
    check("t5_x0_lsu_popped", bus.rd_data, 64'h55);
    tick();

    // 5b: reset with three loads still queued
    bus.byp_rs1 = 5'd3;
    for (int i = 0; i < 3; i++) begin
      set_alu(1, 3, 64'h33);
      set_lsu(1, 5'(12 + i), 64'h1200 + 64'(i));
      tick();
    end
    set_lsu(0, 0, 0);
    rst = 1'b1;
    #1;
    check("t5_rst_rd", bus.rd, 0);
    check("t5_rst_rd_we", bus.rd_we, 0);
    check("t5_rst_rd_data", bus.rd_data, 0);
    check("t5_rst_hit", bus.byp_rs1_hit, 0);
    set_alu(0, 0, 0);
    bus.byp_rs1 = 5'd0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_wb_after_reset", bus.rd_we, 0);
      check("t5_ready_after_reset", bus.lsu_ready, 1);
      tick();
    end

    // 6: forwarding of the in-flight write
    bus.byp_rs1 = 5'd9;
    bus.byp_rs2 = 5'd0;
    set_alu(1, 9, 64'hABC);
    tick();
    set_alu(0, 0, 0);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    check("t6_rs1_hit", bus.byp_rs1_hit, 1);
    check("t6_byp_data", bus.byp_data, 64'hABC);
`else
    check("t6_rs1_hit", bus.byp_rs1_hit, 0);
    check("t6_byp_data", bus.byp_data, 0);
`endif
    check("t6_rs2_hit", bus.byp_rs2_hit, 0);
    tick();
    @(negedge clk);
    check("t6_rs1_after", bus.byp_rs1_hit, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
